// File: rtl/dest_packetizer_mc.sv
// Destination packetizer: strips a destination header byte from rx frames into tid, and prepends tid as a header on tx.
// Optional statistics (rx_drop_count, rx_bad_dest) are built only when DEST_PACKETIZER_MC_STATS_EN is defined.
module dest_packetizer_mc #(
    parameter int NUM_DEST  = 8,
    parameter int TID_WIDTH = 3
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 rxframe_tvalid,
    output logic                 rxframe_tready,
    input  logic                 rxframe_tlast,
    input  logic [7:0]           rxframe_tdata,
    output logic                 txframe_tvalid,
    input  logic                 txframe_tready,
    output logic                 txframe_tlast,
    output logic [7:0]           txframe_tdata,
    output logic                 rxpacket_tvalid,
    input  logic                 rxpacket_tready,
    output logic                 rxpacket_tlast,
    output logic [7:0]           rxpacket_tdata,
    output logic [TID_WIDTH-1:0] rxpacket_tid,
    input  logic                 txpacket_tvalid,
    output logic                 txpacket_tready,
    input  logic                 txpacket_tlast,
    input  logic [7:0]           txpacket_tdata,
    input  logic [TID_WIDTH-1:0] txpacket_tid
`ifdef DEST_PACKETIZER_MC_STATS_EN
    ,
    output logic [15:0]          rx_drop_count,
    output logic                 rx_bad_dest
`endif
);

    localparam logic [1:0] RX_HEADER  = 2'd0;
    localparam logic [1:0] RX_PAYLOAD = 2'd1;
    localparam logic [1:0] RX_DISCARD = 2'd2;
    localparam logic [0:0] TX_HEADER  = 1'b0;
    localparam logic [0:0] TX_PAYLOAD = 1'b1;

    logic [1:0]           rx_state_q, rx_state_d;
    logic [TID_WIDTH-1:0] rx_tid_q, rx_tid_d;
    logic [0:0]           tx_state_q, tx_state_d;
    logic                 rx_fire, hdr_fire, hdr_bad, tx_fire;

    assign rx_fire  = rxframe_tvalid & rxframe_tready;
    assign hdr_fire = rx_fire & (rx_state_q == RX_HEADER);
    assign hdr_bad  = {24'd0, rxframe_tdata} >= 32'(NUM_DEST);
    assign tx_fire  = txframe_tvalid & txframe_tready;

    // Extract side: header and discarded bytes are swallowed, payload is a zero-latency pass-through.
    always_comb begin
        rx_state_d      = rx_state_q;
        rx_tid_d        = rx_tid_q;
        rxframe_tready  = 1'b1;
        rxpacket_tvalid = 1'b0;
        case (rx_state_q)
            RX_HEADER: begin
                if (hdr_fire && !rxframe_tlast) begin
                    if (hdr_bad) begin
                        rx_state_d = RX_DISCARD;
                    end else begin
                        rx_state_d = RX_PAYLOAD;
                        rx_tid_d   = rxframe_tdata[TID_WIDTH-1:0];
                    end
                end
            end
            RX_PAYLOAD: begin
                rxframe_tready  = rxpacket_tready;
                rxpacket_tvalid = rxframe_tvalid;
                if (rx_fire && rxframe_tlast) rx_state_d = RX_HEADER;
            end
            RX_DISCARD: begin
                if (rx_fire && rxframe_tlast) rx_state_d = RX_HEADER;
            end
            default: rx_state_d = RX_HEADER;
        endcase
    end

    assign rxpacket_tdata = rxframe_tdata;
    assign rxpacket_tlast = rxframe_tlast;
    assign rxpacket_tid   = rx_tid_q;

    // Insert side: the header beat reuses the first packet beat's valid, so tid is read only while in TX_HEADER.
    always_comb begin
        tx_state_d      = tx_state_q;
        txframe_tvalid  = txpacket_tvalid & ~areset;
        txframe_tdata   = 8'(txpacket_tid);
        txframe_tlast   = 1'b0;
        txpacket_tready = 1'b0;
        if (tx_state_q == TX_PAYLOAD) begin
            txframe_tdata   = txpacket_tdata;
            txframe_tlast   = txpacket_tlast;
            txpacket_tready = txframe_tready;
            if (tx_fire && txpacket_tlast) tx_state_d = TX_HEADER;
        end else if (tx_fire) begin
            tx_state_d = TX_PAYLOAD;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rx_state_q <= RX_HEADER;
            rx_tid_q   <= '0;
            tx_state_q <= TX_HEADER;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tid_q   <= rx_tid_d;
            tx_state_q <= tx_state_d;
        end
    end

`ifdef DEST_PACKETIZER_MC_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        bad_dest_q;
    logic        drop_ev, bad_ev;

    // A header-only frame counts as one drop even if its destination is also out of range.
    assign drop_ev    = hdr_fire & (rxframe_tlast | hdr_bad);
    assign bad_ev     = hdr_fire & ~rxframe_tlast & hdr_bad;
    assign drop_cnt_d = (drop_ev && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            drop_cnt_q <= '0;
            bad_dest_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            bad_dest_q <= bad_ev;
        end
    end

    assign rx_drop_count = drop_cnt_q;
    assign rx_bad_dest   = bad_dest_q;
`endif

endmodule

// File: tb/tb_dest_packetizer_mc.sv
// Randomized bench for dest_packetizer_mc against a frame-level queue model of both directions.
// Stats checks are compiled in when DEST_PACKETIZER_MC_STATS_EN is defined.
module tb_dest_packetizer_mc;
    localparam int ND = 8;
    localparam int TW = 3;

    logic          aclk = 1'b0;
    logic          areset;
    logic          rxframe_tvalid, rxframe_tready, rxframe_tlast;
    logic [7:0]    rxframe_tdata;
    logic          txframe_tvalid, txframe_tready, txframe_tlast;
    logic [7:0]    txframe_tdata;
    logic          rxpacket_tvalid, rxpacket_tready, rxpacket_tlast;
    logic [7:0]    rxpacket_tdata;
    logic [TW-1:0] rxpacket_tid;
    logic          txpacket_tvalid, txpacket_tready, txpacket_tlast;
    logic [7:0]    txpacket_tdata;
    logic [TW-1:0] txpacket_tid;
`ifdef DEST_PACKETIZER_MC_STATS_EN
    logic [15:0]   rx_drop_count;
    logic          rx_bad_dest;
`endif

    dest_packetizer_mc #(.NUM_DEST(ND), .TID_WIDTH(TW)) dut (
        .aclk(aclk), .areset(areset),
        .rxframe_tvalid(rxframe_tvalid), .rxframe_tready(rxframe_tready),
        .rxframe_tlast(rxframe_tlast), .rxframe_tdata(rxframe_tdata),
        .txframe_tvalid(txframe_tvalid), .txframe_tready(txframe_tready),
        .txframe_tlast(txframe_tlast), .txframe_tdata(txframe_tdata),
        .rxpacket_tvalid(rxpacket_tvalid), .rxpacket_tready(rxpacket_tready),
        .rxpacket_tlast(rxpacket_tlast), .rxpacket_tdata(rxpacket_tdata), .rxpacket_tid(rxpacket_tid),
        .txpacket_tvalid(txpacket_tvalid), .txpacket_tready(txpacket_tready),
        .txpacket_tlast(txpacket_tlast), .txpacket_tdata(txpacket_tdata), .txpacket_tid(txpacket_tid)
`ifdef DEST_PACKETIZER_MC_STATS_EN
        , .rx_drop_count(rx_drop_count), .rx_bad_dest(rx_bad_dest)
`endif
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_bad = 0;
    int rx_acc = 0;
    int tx_acc = 0;
    int exp_drops = 0;
    int exp_bad = 0;
    int seen_bad = 0;
    bit rand_rdy = 1'b0;

    logic [7:0]  scratch[$];
    logic [8:0]  rx_stream[$];   // {last, data}
    logic [16:0] tx_stream[$];   // {tid, last, data}
    logic [16:0] rx_exp[$];      // {tid, last, data}
    logic [8:0]  tx_exp[$];      // {last, data}

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: header-only or out-of-range frames vanish; otherwise payload comes out tagged with the header.
    task automatic add_rx_frame(input logic [7:0] hdr);
        int n = scratch.size();
        rx_stream.push_back({n == 0, hdr});
        for (int i = 0; i < n; i++) rx_stream.push_back({i == n - 1, scratch[i]});
        if (n == 0) exp_drops++;
        else if (int'(hdr) >= ND) begin exp_drops++; exp_bad++; end
        else for (int i = 0; i < n; i++) rx_exp.push_back({hdr, i == n - 1, scratch[i]});
        scratch.delete();
    endtask

    // Model: frame = tid byte then the packet; tid on later beats is noise that must be ignored.
    task automatic add_tx_packet(input logic [7:0] tid);
        int n = scratch.size();
        tx_exp.push_back({1'b0, tid});
        for (int i = 0; i < n; i++) begin
            tx_stream.push_back({(i == 0) ? tid : 8'($urandom_range(0, ND - 1)), i == n - 1, scratch[i]});
            tx_exp.push_back({i == n - 1, scratch[i]});
        end
        scratch.delete();
    endtask

    task automatic send_rx(input logic [7:0] d, input logic l);
        int tgt = rx_acc + 1;
        int guard = 0;
        if (rand_rdy && $urandom_range(0, 3) == 0) begin
            rxframe_tvalid = 1'b0;
            @(posedge aclk); #1;
        end
        rxframe_tvalid = 1'b1; rxframe_tdata = d; rxframe_tlast = l;
        do begin @(posedge aclk); #1; guard++; end while (rx_acc < tgt && guard < 300);
        if (rx_acc < tgt) chk("rx_in_stall", rx_acc, tgt);
        rxframe_tvalid = 1'b0;
    endtask

    task automatic send_tx(input logic [7:0] t, input logic [7:0] d, input logic l);
        int tgt = tx_acc + 1;
        int guard = 0;
        if (rand_rdy && $urandom_range(0, 3) == 0) begin
            txpacket_tvalid = 1'b0;
            @(posedge aclk); #1;
        end
        txpacket_tvalid = 1'b1; txpacket_tid = t[TW-1:0]; txpacket_tdata = d; txpacket_tlast = l;
        do begin @(posedge aclk); #1; guard++; end while (tx_acc < tgt && guard < 300);
        if (tx_acc < tgt) chk("tx_in_stall", tx_acc, tgt);
        txpacket_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (rx_exp.size() != 0 || tx_exp.size() != 0); i++) @(posedge aclk);
        #1;
        chk("rx_left", rx_exp.size(), 0);
        chk("tx_left", tx_exp.size(), 0);
    endtask

    initial begin
        logic [16:0] e;
        logic [8:0]  f;
        areset = 1'b1;
        rxframe_tvalid = 1'b1; rxframe_tlast = 1'b0; rxframe_tdata = 8'h03;
        txpacket_tvalid = 1'b1; txpacket_tlast = 1'b0; txpacket_tdata = 8'h00; txpacket_tid = '0;
        rxpacket_tready = 1'b1; txframe_tready = 1'b1;

        fork
            forever @(negedge aclk) begin
                if (rxframe_tvalid && rxframe_tready) rx_acc++;
                if (txpacket_tvalid && txpacket_tready) tx_acc++;
`ifdef DEST_PACKETIZER_MC_STATS_EN
                if (rx_bad_dest) seen_bad++;
`endif
                if (rxpacket_tvalid && rxpacket_tready) begin
                    $display("rxpacket beat tid=%0d data=%02h last=%0d", rxpacket_tid, rxpacket_tdata, rxpacket_tlast);
                    if (rx_exp.size() == 0) chk("rx_extra", rx_exp.size(), 1);
                    else begin
                        e = rx_exp.pop_front();
                        chk("rx_beat", {15'd0, 8'(rxpacket_tid), rxpacket_tlast, rxpacket_tdata}, {15'd0, e});
                    end
                end
                if (txframe_tvalid && txframe_tready) begin
                    $display("txframe beat data=%02h last=%0d", txframe_tdata, txframe_tlast);
                    if (tx_exp.size() == 0) chk("tx_extra", tx_exp.size(), 1);
                    else begin
                        f = tx_exp.pop_front();
                        chk("tx_beat", {23'd0, txframe_tlast, txframe_tdata}, {23'd0, f});
                    end
                end
            end
            forever begin
                @(posedge aclk); #1;
                if (rand_rdy) begin
                    rxpacket_tready = ($urandom_range(0, 2) != 0);
                    txframe_tready  = ($urandom_range(0, 2) != 0);
                end else begin
                    rxpacket_tready = 1'b1;
                    txframe_tready  = 1'b1;
                end
            end
        join_none

        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_rxpkt_valid", rxpacket_tvalid, 0);
        chk("rst_txfrm_valid", txframe_tvalid, 0);
`ifdef DEST_PACKETIZER_MC_STATS_EN
        chk("rst_drop_count", rx_drop_count, 0);
        chk("rst_bad_dest", rx_bad_dest, 0);
`endif
        @(posedge aclk); #1;
        rxframe_tvalid = 1'b0; txpacket_tvalid = 1'b0;
        areset = 1'b0;
        rx_acc = 0; tx_acc = 0;

        // Directed frames first, then random ones including bad destinations and header-only frames.
        scratch = '{8'hAA, 8'hBB}; add_rx_frame(8'h03);
        scratch = '{8'h11, 8'h22}; add_rx_frame(8'h09);
        scratch = '{8'h55};        add_rx_frame(8'h01);
        add_rx_frame(8'h02);
        scratch = '{8'h66, 8'h67}; add_rx_frame(8'h07);
        for (int k = 0; k < 30; k++) begin
            int n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) scratch.push_back(8'($urandom));
            add_rx_frame(8'($urandom_range(0, 11)));
        end
        scratch = '{8'h10, 8'h20}; add_tx_packet(8'h05);
        for (int k = 0; k < 30; k++) begin
            int n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) scratch.push_back(8'($urandom));
            add_tx_packet(8'($urandom_range(0, ND - 1)));
        end
        $display("model: rx beats=%0d tx beats=%0d drops=%0d bad=%0d", rx_exp.size(), tx_exp.size(), exp_drops, exp_bad);

        rand_rdy = 1'b1;
        fork
            while (rx_stream.size() != 0) begin
                f = rx_stream.pop_front();
                send_rx(f[7:0], f[8]);
            end
            while (tx_stream.size() != 0) begin
                e = tx_stream.pop_front();
                send_tx(e[16:9], e[7:0], e[8]);
            end
        join
        drain();
        rand_rdy = 1'b0;
        @(posedge aclk); #1;
`ifdef DEST_PACKETIZER_MC_STATS_EN
        chk("drop_count", rx_drop_count, exp_drops);
        chk("bad_dest_pulses", seen_bad, exp_bad);
`endif

        // Reset mid-frame on both sides: partial rx is abandoned, partial tx packet is truncated.
        rx_exp.push_back({8'h04, 1'b0, 8'hAB});
        tx_exp.push_back({1'b0, 8'h02});
        tx_exp.push_back({1'b0, 8'hCD});
        fork
            begin send_rx(8'h04, 1'b0); send_rx(8'hAB, 1'b0); end
            send_tx(8'h02, 8'hCD, 1'b0);
        join
        drain();
        areset = 1'b1;
        rxframe_tvalid = 1'b1; rxframe_tdata = 8'h77; rxframe_tlast = 1'b0;
        txpacket_tvalid = 1'b1; txpacket_tdata = 8'h99; txpacket_tlast = 1'b1;
        @(negedge aclk);
        chk("midrst_rxpkt_valid", rxpacket_tvalid, 0);
        chk("midrst_txfrm_valid", txframe_tvalid, 0);
        @(posedge aclk); #1;
        rxframe_tvalid = 1'b0; txpacket_tvalid = 1'b0;
        areset = 1'b0;
`ifdef DEST_PACKETIZER_MC_STATS_EN
        chk("midrst_drop_count", rx_drop_count, 0);
`endif
        rx_exp.push_back({8'h06, 1'b1, 8'h77});
        tx_exp.push_back({1'b0, 8'h05});
        tx_exp.push_back({1'b0, 8'h10});
        tx_exp.push_back({1'b1, 8'h20});
        rand_rdy = 1'b1;
        fork
            begin send_rx(8'h06, 1'b0); send_rx(8'h77, 1'b1); end
            begin send_tx(8'h05, 8'h10, 1'b0); send_tx(8'h03, 8'h20, 1'b1); end
        join
        drain();
        rand_rdy = 1'b0;

`ifdef DEST_PACKETIZER_MC_STATS_EN
        // Saturation: 65537 header-only frames back to back, header state always ready.
        @(posedge aclk); #1;
        rxframe_tvalid = 1'b1; rxframe_tlast = 1'b1; rxframe_tdata = 8'h01;
        repeat (65537) @(posedge aclk);
        #1;
        rxframe_tvalid = 1'b0;
        @(negedge aclk);
        chk("drop_saturate", rx_drop_count, 32'h0000FFFF);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
